cla_nibble_sequencer: RTL and testbench
=======================================

CLA_NIBBLE_SEQUENCER -- requirements
Module: cla_nibble_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits; it SHALL be a multiple of 4 and at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the requester presents an operand set.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an operand set.
REQ-006 SHALL have port a, input, WIDTH bits: operand A.
REQ-007 SHALL have port b, input, WIDTH bits: operand B.
REQ-008 SHALL have port cin, input, 1 bit: carry-in to bit 0.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is held on the outputs.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port sum, output, WIDTH bits: a + b + cin, modulo 2^WIDTH.
REQ-012 SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-013 SHALL have port ovf, output, 1 bit: signed overflow, equal to the carry into the MSB XOR cout.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE; NIB = WIDTH/4.
REQ-016 SHALL drive in_ready = 1 only in IDLE.
REQ-017 SHALL accept an operand set when in_valid && in_ready at a clock edge: latch a, b and cin, clear the nibble index to 0, and go to RUN.
REQ-018 SHALL, in RUN, process one nibble per cycle: feed latched nibble idx of a and b plus the carry register into the 4-bit lookahead slice, write sum nibble idx = (a^b) nibble XOR slice carries [3:0], load the carry register with slice carry[4], and increment idx.
REQ-019 SHALL capture the carry into bit WIDTH-1 (slice carry[3] on the last nibble) for ovf.
REQ-020 SHALL go from RUN to DONE on the edge that processes nibble NIB-1, so out_valid rises exactly NIB cycles after the accept edge (4 cycles when WIDTH=16; 1 cycle when WIDTH=4).
REQ-021 SHALL, in DONE, hold out_valid = 1 and keep sum, cout and ovf stable until out_ready = 1.
REQ-022 SHALL, on the edge where out_valid && out_ready, clear out_valid and go to IDLE; in_ready SHALL rise the following cycle, with no same-cycle bypass.
REQ-023 SHALL ignore changes on in_valid, a, b and cin while busy; the latched operands alone determine the result.
REQ-024 SHALL leave sum, cout and ovf at their last completed values while in IDLE and RUN; they SHALL update only when DONE is entered.
REQ-025 SHALL accept back-to-back transactions when out_ready is held high, giving a throughput of one result per NIB+2 cycles.
REQ-026 SHALL wrap idx naturally at NIB-1 into DONE; idx SHALL never index beyond nibble NIB-1.

Reset
REQ-027 SHALL, while rst_n = 0, force: state IDLE, in_ready 1, out_valid 0, busy 0, sum 0, cout 0, ovf 0, idx 0, carry register 0.
REQ-028 SHALL abandon an in-flight operation when reset is asserted mid-RUN or mid-DONE, with no result emitted after rst_n is released.
REQ-029 SHALL allow acceptance on the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL place the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and NIBBLE_W=4 in the shared package cla_pkg.
REQ-031 SHALL instantiate the existing 4-bit lookahead module carry_logic exactly once as its sub-module; no other adder logic SHALL be used.

Verification (WIDTH=16)
REQ-032 SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> out_valid 4 cycles after accept; sum=0x0000, cout=1, ovf=0.
REQ-033 SHALL cover: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-034 SHALL cover: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0; a and b are randomized during RUN and the result is unaffected.
REQ-035 SHALL cover: out_ready held low for 10 cycles in DONE -> out_valid and sum are stable throughout, in_ready stays 0, and a second in_valid is not accepted.
REQ-036 SHALL cover: rst_n pulsed low 2 cycles after accept -> all outputs are at reset values immediately, no out_valid follows, and a new transaction then completes correctly.
REQ-037 SHALL cover: out_ready=1 and in_valid=1 held continuously -> a result every 6 cycles, each checked against a reference a+b+cin.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial lookahead adder: FSM encoding and slice width.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/carry_logic.sv
// 4-bit carry-lookahead slice: carries c[0..4] and propagate bits from one nibble of operands.
module carry_logic
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] p,
  output logic [NIBBLE_W:0]   c
);

  logic [NIBBLE_W-1:0] g;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p/cin, so no ripple through the slice.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Sequential adder: one lookahead slice reused for WIDTH/4 cycles, valid/ready on both sides.
module cla_nibble_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  // Handshake: a transfer happens on any rising edge where valid && ready are both high;
  // valid holds its payload until that edge, and ready never depends on valid.

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic                carry_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    work_q;
  logic [WIDTH-1:0]    work_next;
  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_p;
  logic [NIBBLE_W:0]   slice_c;
  logic                last_nib;
  int                  sel;

  assign sel      = int'(idx) * NIBBLE_W;
  assign slice_a  = a_q[sel +: NIBBLE_W];
  assign slice_b  = b_q[sel +: NIBBLE_W];
  assign last_nib = (idx == IDX_W'(NIB - 1));

  carry_logic u_carry_logic (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .p   (slice_p),
    .c   (slice_c)
  );

  // Partial sum accumulates here so the visible sum only changes when DONE is entered.
  always_comb begin
    work_next = work_q;
    work_next[sel +: NIBBLE_W] = slice_p ^ slice_c[NIBBLE_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          work_q  <= work_next;
          carry_q <= slice_c[NIBBLE_W];
          if (last_nib) begin
            sum   <= work_next;
            cout  <= slice_c[NIBBLE_W];
            ovf   <= slice_c[NIBBLE_W-1] ^ slice_c[NIBBLE_W];
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer (WIDTH=16): vector table, corner sequences, random and streaming runs.
module tb_cla_nibble_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, ovf, busy;
  logic [W-1:0] sum;

  int checks = 0;
  int failures = 0;
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  cla_nibble_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer addition; returns {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
    logic [W:0] full;
    int sx, sy, ss;
    logic ov;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    ss = sx + sy + int'(ci);
    ov = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
    return {ov, full};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'd0);
    check({tag, "_cout"}, 32'(cout), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  // driver tasks
  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    check("accept_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = ci;
    tick();
    in_valid = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input bit scramble, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        in_valid = 1'($urandom);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    if (out_valid !== 1'b1) check("done_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_one(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic [W+1:0] exp, input bit scramble,
                         input int hold);
    int lat;
    accept(x, y, ci);
    wait_done(scramble, lat);
    check({name, "_latency"}, 32'(lat), 32'd4);
    for (int i = 0; i < hold; i++) tick();
    check({name, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
    check({name, "_cout"}, 32'(cout), 32'(exp[W]));
    check({name, "_ovf"}, 32'(ovf), 32'(exp[W+1]));
    release_result();
  endtask

  initial begin
    logic [W-1:0] x, y;
    logic         ci;
    logic [W+1:0] e, got;
    int           seen, n_res, last_cyc;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    vecs[7] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};

    // Reset state, then accept on the very first edge after release.
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // Vector table; entry 2 scrambles the inputs while the operation runs.
    for (int i = 0; i < 8; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
              {vecs[i].ovf, vecs[i].cout, vecs[i].sum}, (i == 2), 0);
    end

    // DONE held for 10 cycles with a competing request.
    e = ref_add(16'hA5A5, 16'h0F0F, 1'b0);
    accept(16'hA5A5, 16'h0F0F, 1'b0);
    wait_done(1'b0, seen);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      tick();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(e[W-1:0]));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_result();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("hold_no_second_result", 32'(seen), 32'd0);
    check("hold_idle_busy", 32'(busy), 32'd0);

    // Reset pulsed two cycles into RUN.
    accept(16'h1111, 16'h2222, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("midreset_no_result", 32'(seen), 32'd0);
    run_one("post_reset", 16'h2468, 16'h1357, 1'b1, ref_add(16'h2468, 16'h1357, 1'b1), 1'b0, 0);

    // Random single transactions with random consumer stall.
    for (int i = 0; i < 20; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      ci = 1'($urandom);
      run_one("rand", x, y, ci, ref_add(x, y, ci), 1'b1, $urandom_range(0, 3));
    end

    // Streaming: in_valid and out_ready both held high.
    out_ready = 1'b1;
    in_valid = 1'b1;
    n_res = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 76; cyc++) begin
      if (cyc == 66) in_valid = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          got = {ovf, cout, sum};
          check("stream_result", 32'(got), 32'(e));
        end
        if (last_cyc >= 0) check("stream_spacing", 32'(cyc - last_cyc), 32'd6);
        last_cyc = cyc;
        n_res++;
      end
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      if (in_valid && in_ready) exp_q.push_back(ref_add(a, b, cin));
      tick();
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);
    check("stream_result_count", 32'(n_res), 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
